// File: rtl/jam1_xfer_pkg.sv
// Shared definitions for the 16-bit transfer-bus scheduler: FSM states,
// destination register indices and the default destination count.
package jam1_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_LOCKED = 2'd2
    } xfer_state_e;

    localparam int XFER_NDST_DEF = 8;

    // Transfer-register bank slots, in reg_xfer_load bit order
    localparam logic [3:0] XDST_PC  = 4'd0;
    localparam logic [3:0] XDST_SP  = 4'd1;
    localparam logic [3:0] XDST_X   = 4'd2;
    localparam logic [3:0] XDST_Y   = 4'd3;
    localparam logic [3:0] XDST_MAR = 4'd4;
    localparam logic [3:0] XDST_T   = 4'd5;
    localparam logic [3:0] XDST_D   = 4'd6;
    localparam logic [3:0] XDST_IR  = 4'd7;

endpackage

// File: rtl/xfer_bus_sched_if.sv
// Request/grant and strobe bundle between pipeline control and the
// transfer-bus scheduler.
interface xfer_bus_sched_if #(
    parameter int NSRC = 4,
    parameter int NDST = 8
);
    localparam int DW = $clog2(NDST);

    logic [NSRC-1:0]    req;
    logic [NSRC*DW-1:0] req_dst;
    logic [NSRC-1:0]    req_lock;
    logic               stall;
    logic [NSRC-1:0]    gnt;
    logic [NSRC-1:0]    xfer_src_oe_n;
    logic [NDST-1:0]    xfer_load_n;
    logic               busy;

    modport master (
        output req, req_dst, req_lock, stall,
        input  gnt, xfer_src_oe_n, xfer_load_n, busy
    );

    modport slave (
        input  req, req_dst, req_lock, stall,
        output gnt, xfer_src_oe_n, xfer_load_n, busy
    );

endinterface

// File: rtl/xfer_arb.sv
// Combinational winner select for the transfer bus. Fixed priority (index 0
// highest) by default; round-robin from a pointer when XFER_RR_EN is defined.
module xfer_arb #(
    parameter int NSRC = 4,
    parameter int IW   = 2
) (
    input  logic [NSRC-1:0] req,
`ifdef XFER_RR_EN
    input  logic [IW-1:0]   ptr,
`endif
    output logic [NSRC-1:0] win_oh,
    output logic [IW-1:0]   win_idx,
    output logic            win_vld
);

    logic hit_s;

`ifdef XFER_RR_EN
    int          cand_int_s;
    logic [IW-1:0] cand_s;

    // Search starts at the pointer and wraps; first requester found wins
    always_comb begin
        win_oh     = '0;
        win_idx    = '0;
        win_vld    = 1'b0;
        hit_s      = 1'b0;
        cand_int_s = 0;
        cand_s     = '0;
        for (int k = 0; k < NSRC; k++) begin
            cand_int_s = (int'(ptr) + k >= NSRC) ? (int'(ptr) + k - NSRC) : (int'(ptr) + k);
            cand_s     = IW'(cand_int_s);
            hit_s      = req[cand_s] && !win_vld;
            win_oh[cand_s] = win_oh[cand_s] | hit_s;
            win_idx    = hit_s ? cand_s : win_idx;
            win_vld    = win_vld | hit_s;
        end
    end
`else
    // Lowest index with a pending request wins
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        hit_s   = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            hit_s     = req[k] && !win_vld;
            win_oh[k] = hit_s;
            win_idx   = hit_s ? IW'(k) : win_idx;
            win_vld   = win_vld | hit_s;
        end
    end
`endif

endmodule

// File: rtl/xfer_bus_sched.sv
// Transfer-bus scheduler: grants the 16-bit bus to one pipeline stage per cycle
// and sequences the registered active-low source/load strobes. Round-robin
// arbitration is selected with the XFER_RR_EN macro.
module xfer_bus_sched
    import jam1_xfer_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int NDST = XFER_NDST_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    xfer_bus_sched_if.slave bus
);

    localparam int DW = $clog2(NDST);
    localparam int IW = $clog2(NSRC);

    xfer_state_e      state_r;
    xfer_state_e      state_nx_s;
    logic [IW-1:0]    own_r;
    logic [DW-1:0]    dst_r;
    logic             lock_r;

    logic             grant_s;
    logic [IW-1:0]    gnt_idx_s;
    logic [NSRC-1:0]  gnt_oh_s;
    logic [NSRC-1:0]  own_oh_s;
    logic [NSRC-1:0]  arb_req_s;
    logic [NSRC-1:0]  arb_oh_s;
    logic [IW-1:0]    arb_idx_s;
    logic             arb_vld_s;
    logic [DW-1:0]    dst_arr_s [NSRC];
    logic [NDST-1:0]  dst_dec_s;

    logic [NSRC-1:0]  gnt_r;
    logic [NSRC-1:0]  src_oe_n_r;
    logic [NDST-1:0]  load_n_r;
    logic             busy_r;

`ifdef XFER_RR_EN
    logic [IW-1:0]    ptr_r;
`endif

    xfer_arb #(
        .NSRC (NSRC),
        .IW   (IW)
    ) u_arb (
        .req     (arb_req_s),
`ifdef XFER_RR_EN
        .ptr     (ptr_r),
`endif
        .win_oh  (arb_oh_s),
        .win_idx (arb_idx_s),
        .win_vld (arb_vld_s)
    );

    // One-hot view of the current bus owner
    always_comb begin
        own_oh_s        = '0;
        own_oh_s[own_r] = 1'b1;
    end

    // During a grant cycle the owner's req is still its old request, so hide it
    always_comb begin
        arb_req_s = bus.req;
        if (state_r == ST_XFER) begin
            arb_req_s = bus.req & ~own_oh_s;
        end else begin
            arb_req_s = bus.req;
        end
    end

    // Unpack per-requester destination indices
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            dst_arr_s[i] = bus.req_dst[i*DW +: DW];
        end
    end

    // Destination decode; indices at or above NDST select nothing
    always_comb begin
        dst_dec_s = '0;
        for (int d = 0; d < NDST; d++) begin
            dst_dec_s[d] = (int'(dst_r) == d);
        end
    end

    // Next-state and grant decision
    always_comb begin
        state_nx_s = state_r;
        grant_s    = 1'b0;
        gnt_idx_s  = arb_idx_s;
        gnt_oh_s   = arb_oh_s;
        case (state_r)
            ST_IDLE: begin
                if (!bus.stall && arb_vld_s) begin
                    grant_s    = 1'b1;
                    state_nx_s = ST_XFER;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (lock_r) begin
                    state_nx_s = ST_LOCKED;
                end else if (!bus.stall && arb_vld_s) begin
                    grant_s    = 1'b1;
                    state_nx_s = ST_XFER;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                gnt_idx_s = own_r;
                gnt_oh_s  = own_oh_s;
                if (bus.stall) begin
                    state_nx_s = ST_LOCKED;
                end else if (bus.req[own_r]) begin
                    grant_s    = 1'b1;
                    state_nx_s = ST_XFER;
                end else if (!bus.req_lock[own_r]) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_LOCKED;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register and transfer context captured at grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            own_r   <= '0;
            dst_r   <= '0;
            lock_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (grant_s) begin
                own_r  <= gnt_idx_s;
                dst_r  <= dst_arr_s[gnt_idx_s];
                lock_r <= bus.req_lock[gnt_idx_s];
            end
        end
    end

    // Registered outputs; strobes fire the cycle after the grant pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r      <= '0;
            src_oe_n_r <= '1;
            load_n_r   <= '1;
            busy_r     <= 1'b0;
        end else begin
            gnt_r      <= grant_s ? gnt_oh_s : '0;
            src_oe_n_r <= (state_r == ST_XFER) ? ~own_oh_s : '1;
            load_n_r   <= (state_r == ST_XFER) ? ~dst_dec_s : '1;
            busy_r     <= (state_nx_s != ST_IDLE) || (state_r == ST_XFER);
        end
    end

`ifdef XFER_RR_EN
    // Round-robin pointer moves just past each winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (grant_s) begin
            ptr_r <= (gnt_idx_s == IW'(NSRC - 1)) ? '0 : gnt_idx_s + IW'(1);
        end
    end
`endif

    assign bus.gnt           = gnt_r;
    assign bus.xfer_src_oe_n = src_oe_n_r;
    assign bus.xfer_load_n   = load_n_r;
    assign bus.busy          = busy_r;

endmodule

// File: tb/tb_xfer_bus_sched.sv
// Directed bench for xfer_bus_sched: a cycle table for single, contention,
// stall and lock traffic plus hand sequences for reset and out-of-range dst.
module tb_xfer_bus_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    xfer_bus_sched_if #(.NSRC(4), .NDST(8)) ifa ();
    xfer_bus_sched_if #(.NSRC(4), .NDST(6)) ifb ();

    xfer_bus_sched #(.NSRC(4), .NDST(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    xfer_bus_sched #(.NSRC(4), .NDST(6)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    typedef struct {
        logic [3:0]  req;
        logic [11:0] dst;
        logic [3:0]  lock;
        logic        stall;
        logic [3:0]  gnt;
        logic [3:0]  oe;
        logic [7:0]  load;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [11:0] D_SGL = {3'd0, 3'd3, 3'd0, 3'd0};
    localparam logic [11:0] D_CON = {3'd0, 3'd6, 3'd5, 3'd0};
    localparam logic [11:0] D_STL = {3'd0, 3'd0, 3'd4, 3'd2};
    localparam logic [11:0] D_LCK = {3'd7, 3'd0, 3'd0, 3'd1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [11:0] d, input logic [3:0] l,
                       input logic s, input logic [3:0] g, input logic [3:0] o,
                       input logic [7:0] ld, input logic b);
        vec_t v;
        v.req = r; v.dst = d; v.lock = l; v.stall = s;
        v.gnt = g; v.oe = o; v.load = ld; v.busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Each row: inputs sampled at one edge, outputs expected just after it
        add(4'b0100, D_SGL, 4'b0000, 1'b0, 4'b0100, 4'b1111, 8'hFF, 1'b1);
        add(4'b0100, D_SGL, 4'b0000, 1'b0, 4'b0000, 4'b1011, 8'hF7, 1'b1);
        add(4'b0000, D_SGL, 4'b0000, 1'b0, 4'b0000, 4'b1111, 8'hFF, 1'b0);
        add(4'b0110, D_CON, 4'b0000, 1'b0, 4'b0010, 4'b1111, 8'hFF, 1'b1);
        add(4'b0110, D_CON, 4'b0000, 1'b0, 4'b0100, 4'b1101, 8'hDF, 1'b1);
        add(4'b0110, D_CON, 4'b0000, 1'b0, 4'b0010, 4'b1011, 8'hBF, 1'b1);
        add(4'b0110, D_CON, 4'b0000, 1'b0, 4'b0100, 4'b1101, 8'hDF, 1'b1);
        add(4'b0000, D_CON, 4'b0000, 1'b0, 4'b0000, 4'b1011, 8'hBF, 1'b1);
        add(4'b0000, D_CON, 4'b0000, 1'b0, 4'b0000, 4'b1111, 8'hFF, 1'b0);
        add(4'b0001, D_STL, 4'b0000, 1'b0, 4'b0001, 4'b1111, 8'hFF, 1'b1);
        add(4'b0011, D_STL, 4'b0000, 1'b1, 4'b0000, 4'b1110, 8'hFB, 1'b1);
        add(4'b0010, D_STL, 4'b0000, 1'b1, 4'b0000, 4'b1111, 8'hFF, 1'b0);
        add(4'b0010, D_STL, 4'b0000, 1'b1, 4'b0000, 4'b1111, 8'hFF, 1'b0);
        add(4'b0010, D_STL, 4'b0000, 1'b0, 4'b0010, 4'b1111, 8'hFF, 1'b1);
        add(4'b0010, D_STL, 4'b0000, 1'b0, 4'b0000, 4'b1101, 8'hEF, 1'b1);
        add(4'b0000, D_STL, 4'b0000, 1'b0, 4'b0000, 4'b1111, 8'hFF, 1'b0);
        add(4'b0001, D_LCK, 4'b0001, 1'b0, 4'b0001, 4'b1111, 8'hFF, 1'b1);
        add(4'b1001, D_LCK, 4'b0001, 1'b0, 4'b0000, 4'b1110, 8'hFD, 1'b1);
        add(4'b1000, D_LCK, 4'b0001, 1'b0, 4'b0000, 4'b1111, 8'hFF, 1'b1);
        add(4'b1000, D_LCK, 4'b0001, 1'b1, 4'b0000, 4'b1111, 8'hFF, 1'b1);
        add(4'b1001, D_LCK, 4'b0001, 1'b0, 4'b0001, 4'b1111, 8'hFF, 1'b1);
        add(4'b1001, D_LCK, 4'b0001, 1'b0, 4'b0000, 4'b1110, 8'hFD, 1'b1);
        add(4'b1000, D_LCK, 4'b0000, 1'b0, 4'b0000, 4'b1111, 8'hFF, 1'b0);
        add(4'b1000, D_LCK, 4'b0000, 1'b0, 4'b1000, 4'b1111, 8'hFF, 1'b1);
        add(4'b1000, D_LCK, 4'b0000, 1'b0, 4'b0000, 4'b0111, 8'h7F, 1'b1);
        add(4'b0000, D_LCK, 4'b0000, 1'b0, 4'b0000, 4'b1111, 8'hFF, 1'b0);

        ifa.req = 4'b1111; ifa.req_dst = '0; ifa.req_lock = '0; ifa.stall = 1'b0;
        ifb.req = 4'b0000; ifb.req_dst = '0; ifb.req_lock = '0; ifb.stall = 1'b0;

        // Held in reset with every requester active
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.gnt",  ifa.gnt,           32'h0);
        chk("rst.oe",   ifa.xfer_src_oe_n, 32'hF);
        chk("rst.load", ifa.xfer_load_n,   32'hFF);
        chk("rst.busy", ifa.busy,          32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.gnt",  ifa.gnt,           32'h1);
        chk("rel.oe",   ifa.xfer_src_oe_n, 32'hF);
        chk("rel.busy", ifa.busy,          32'h1);
        @(posedge clk);
        #1;
        chk("rel2.gnt",  ifa.gnt,           32'h2);
        chk("rel2.oe",   ifa.xfer_src_oe_n, 32'hE);
        chk("rel2.load", ifa.xfer_load_n,   32'hFE);

        // Reset in the middle of a strobe cycle drops it at once
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.gnt",  ifa.gnt,           32'h0);
        chk("mid.oe",   ifa.xfer_src_oe_n, 32'hF);
        chk("mid.load", ifa.xfer_load_n,   32'hFF);
        chk("mid.busy", ifa.busy,          32'h0);
        ifa.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post.gnt", ifa.gnt,           32'h0);
        chk("post.oe",  ifa.xfer_src_oe_n, 32'hF);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ifa.req      = vecs[i].req;
            ifa.req_dst  = vecs[i].dst;
            ifa.req_lock = vecs[i].lock;
            ifa.stall    = vecs[i].stall;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.gnt", i),  ifa.gnt,           32'(vecs[i].gnt));
            chk($sformatf("v%0d.oe", i),   ifa.xfer_src_oe_n, 32'(vecs[i].oe));
            chk($sformatf("v%0d.load", i), ifa.xfer_load_n,   32'(vecs[i].load));
            chk($sformatf("v%0d.busy", i), ifa.busy,          32'(vecs[i].busy));
        end

        // Six-register bank: index 7 is granted but loads nothing
        @(negedge clk);
        ifb.req     = 4'b0001;
        ifb.req_dst = {3'd0, 3'd0, 3'd0, 3'd7};
        @(posedge clk);
        #1;
        chk("oor.gnt", ifb.gnt, 32'h1);
        @(posedge clk);
        #1;
        chk("oor.oe",   ifb.xfer_src_oe_n, 32'hE);
        chk("oor.load", ifb.xfer_load_n,   32'h3F);
        chk("oor.busy", ifb.busy,          32'h1);
        @(negedge clk);
        ifb.req = 4'b0000;
        @(posedge clk);
        #1;
        chk("oor.idle", ifb.xfer_src_oe_n, 32'hF);
        chk("oor.bidle", ifb.busy,         32'h0);

        // Top in-range slot of the six-register bank
        @(negedge clk);
        ifb.req     = 4'b0001;
        ifb.req_dst = {3'd0, 3'd0, 3'd0, 3'd5};
        @(posedge clk);
        #1;
        chk("top.gnt", ifb.gnt, 32'h1);
        @(posedge clk);
        #1;
        chk("top.load", ifb.xfer_load_n, 32'h1F);
        @(negedge clk);
        ifb.req = 4'b0000;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xfer_bus_sched.md
# xfer_bus_sched

Scheduler for the 16-bit transfer bus: shares the bus between NSRC requesting pipeline stages and sequences the active-low load strobes of the 16-bit transfer registers (PC, SP, X, Y, …). One transfer per granted cycle, registered strobes, optional bus lock for back-to-back transfers. Sits between pipeline control logic and the transfer-register bank in the main-bus area.

## Interface
Parameters:
- NSRC, 4, number of requesters (2..8)
- NDST, 8, number of destination registers (2..16)
- DW, $clog2(NDST), destination index width (derived, not overridable)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NSRC  per-requester transfer request, active high, held until granted
- req_dst  in  NSRC*DW  destination index per requester, packed, requester i at [i*DW +: DW]
- req_lock  in  NSRC  requester wants to keep the bus after this transfer
- stall  in  1  pipeline stall; freezes scheduling
- gnt  out  NSRC  one-hot grant pulse, one cycle per accepted transfer
- xfer_src_oe_n  out  NSRC  active-low bus drive enable for the granted source
- xfer_load_n  out  NDST  active-low one-hot load strobe to destination reg_xfer_load
- busy  out  1  bus owned (strobe cycle or lock active)

## Operation
- States: IDLE, XFER, LOCKED.
- IDLE: if !stall and any req: pick winner, pulse gnt[w], latch w and req_dst[w] → XFER. Otherwise stay.
- XFER: drive xfer_src_oe_n[w]=0, xfer_load_n[dst]=0 for exactly one cycle. Next: if req_lock[w] sampled at grant → LOCKED, else IDLE (or directly grant next winner, see back-to-back).
- Back-to-back: in XFER with !stall, a new winner may be granted in the same cycle; next cycle is XFER for that winner. Sustained throughput one transfer/cycle.
- LOCKED: only owner w is eligible; req[w] high → gnt[w], XFER; req[w] low with req_lock[w] low → IDLE; stall holds.
- stall: no new grant; an XFER already issued completes (strobe not extended, not repeated); LOCKED holds.
- Out-of-range req_dst (≥NDST): transfer granted, no xfer_load_n asserted, src enable still asserted.
- At most one bit of xfer_load_n and xfer_src_oe_n low at any time; gnt at most one-hot.
- Arbitration priority: fixed, lowest index wins (overridden by Configuration).

## Timing
- Reset (async, immediate): state IDLE, gnt=0, xfer_src_oe_n all 1, xfer_load_n all 1, busy=0, RR pointer=0.
- Latency: req high at edge N (sampled) → gnt high cycle N+1 → strobes low cycle N+2; destination captures at edge ending N+2.
- gnt and strobes are registered outputs; no combinational path from req to any output.
- Requester drops req the cycle after seeing gnt; if req still high it is a new request.
- busy=1 in XFER and LOCKED.
- Reset asserted mid-XFER: strobes deassert immediately; transfer is lost, no retry.

## Configuration
- XFER_RR_EN defined: round-robin arbitration; pointer advances to (winner+1) mod NSRC after each grant; no requester waits more than NSRC−1 grants.
- Not defined: fixed priority, index 0 highest; pointer logic absent.

## Structure
- Shared package jam1_xfer_pkg: state enum (IDLE/XFER/LOCKED), destination index constants (XDST_PC, XDST_SP, XDST_X, XDST_Y, …), NDST default.
- One sub-module: xfer_arb (combinational winner select, fixed or RR from pointer input, one-hot out); FSM, latches, strobe decode in top.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111 → all strobes 1, gnt 0; release → first gnt[0] one cycle later.
- Single: req[2]=1, dst=3 → gnt=4'b0100 cycle N+1, xfer_load_n=8'b1111_0111 and xfer_src_oe_n=4'b1011 cycle N+2 only.
- Contention: req=4'b0110 held → fixed: gnt[1] then gnt[2]; XFER_RR_EN: pointer rotates, alternating 1,2,1,2 with one transfer/cycle.
- Lock: req[0]+req_lock[0] at grant, then req[3] pending → req[3] not granted until req_lock[0]=0 and req[0]=0.
- Stall: stall=1 during XFER with req[1] pending → current strobe completes one cycle, no gnt until stall=0.
- Out-of-range: NDST=6, dst=7 → gnt issued, xfer_load_n stays all 1.
